// File: rtl/gate_lab_checker.sv
// Stimulus driver and checker for the two-input gate lab board.
// Sweeps (a,b) over key, samples led after settling, scores each LED.
module gate_lab_checker #(
    parameter int w_key         = 4,
    parameter int w_led         = 8,
    parameter int settle_cycles = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [w_key-1:0] key,
    input  logic [w_led-1:0] led,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       fail_mask,
    output logic [2:0]       err_count
);

    localparam int cw = (settle_cycles < 1) ? 1 : $clog2(settle_cycles + 1);
    localparam logic [cw-1:0] settle_last = cw'(settle_cycles);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_FIN
    } state_t;

    state_t        state, state_n;
    logic [1:0]    vec, vec_n;
    logic [cw-1:0] cnt, cnt_n;
    logic [7:0]    mask_n;
    logic [2:0]    err_n;
    logic          pass_n;
    logic [7:0]    exp_led;
    logic [7:0]    mismatch;
    logic          a, b;
    logic          unused_led;

    // Only led[7:0] is scored; wider buses are tolerated.
    assign unused_led = ^led;

    assign a = vec[0];
    assign b = vec[1];
    assign exp_led = {~(a | b), ~(a | b), ~(a & b), ~(a & b),
                      a ^ b, a & b, a ^ b, a ^ b};
    assign mismatch = led[7:0] ^ exp_led;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            vec       <= 2'd0;
            cnt       <= '0;
            fail_mask <= 8'd0;
            err_count <= 3'd0;
            pass      <= 1'b0;
        end else begin
            state     <= state_n;
            vec       <= vec_n;
            cnt       <= cnt_n;
            fail_mask <= mask_n;
            err_count <= err_n;
            pass      <= pass_n;
        end
    end

    always_comb begin
        state_n = state;
        vec_n   = vec;
        cnt_n   = cnt;
        mask_n  = fail_mask;
        err_n   = err_count;
        pass_n  = pass;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_DRIVE;
                    vec_n   = 2'd0;
                    cnt_n   = '0;
                    mask_n  = 8'd0;
                    err_n   = 3'd0;
                    pass_n  = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (cnt == settle_last) begin
                    cnt_n  = '0;
                    mask_n = fail_mask | mismatch;
                    if ((|mismatch) && (err_count < 3'd4)) begin
                        err_n = err_count + 3'd1;
                    end
                    if (vec == 2'd3) begin
                        state_n = ST_FIN;
                        pass_n  = (mask_n == 8'd0);
                    end else begin
                        vec_n = vec + 2'd1;
                    end
                end else begin
                    cnt_n = cnt + cw'(1);
                end
            end
            ST_FIN: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign key  = (state == ST_DRIVE) ? w_key'(vec) : '0;
    assign busy = (state == ST_DRIVE);
    assign done = (state == ST_FIN);

endmodule

// File: tb/tb_gate_lab_checker.sv
// Bench for gate_lab_checker: table, random faults, timing corners.
// Two instances cover settle_cycles = 2 and 0.
module tb_gate_lab_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, start_b;
    logic [3:0] key_a;
    logic [1:0] key_b;
    logic [7:0] led_a;
    logic [9:0] led_b;
    logic       busy_a, done_a, pass_a;
    logic       busy_b, done_b, pass_b;
    logic [7:0] mask_a, mask_b;
    logic [2:0] err_a, err_b;
    logic [7:0] s0_a, s1_a, s0_b, s1_b;
    logic [1:0] junk_b;

    int checks   = 0;
    int failures = 0;
    bit sel      = 1'b0;

    function automatic logic [7:0] lab(input logic [1:0] ab);
        logic x, y;
        x = ab[0];
        y = ab[1];
        return {~(x | y), ~(x | y), ~(x & y), ~(x & y),
                x ^ y, x & y, x ^ y, x ^ y};
    endfunction

    assign led_a = (lab(key_a[1:0]) & ~s0_a) | s1_a;
    assign led_b = {junk_b, (lab(key_b) & ~s0_b) | s1_b};

    always @(negedge clk) junk_b = 2'($urandom);

    gate_lab_checker #(.w_key(4), .w_led(8), .settle_cycles(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .key(key_a),
        .led(led_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_mask(mask_a), .err_count(err_a)
    );

    gate_lab_checker #(.w_key(2), .w_led(10), .settle_cycles(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .key(key_b),
        .led(led_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_mask(mask_b), .err_count(err_b)
    );

    logic [3:0] key_v;
    logic       busy_v, done_v, pass_v;
    logic [7:0] mask_v;
    logic [2:0] err_v;
    assign key_v  = sel ? {2'b00, key_b} : key_a;
    assign busy_v = sel ? busy_b : busy_a;
    assign done_v = sel ? done_b : done_a;
    assign pass_v = sel ? pass_b : pass_a;
    assign mask_v = sel ? mask_b : mask_a;
    assign err_v  = sel ? err_b : err_a;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input bit x);
        if (sel) start_b = x;
        else start_a = x;
    endtask

    task automatic set_fault(input logic [7:0] s0, input logic [7:0] s1);
        if (sel) begin
            s0_b = s0;
            s1_b = s1;
        end else begin
            s0_a = s0;
            s1_a = s1;
        end
    endtask

    // Reference: apply the stuck-at faults to the truth table directly.
    task automatic ref_sweep(input logic [7:0] s0, input logic [7:0] s1,
                             output logic [7:0] m, output int e);
        logic [7:0] g, r;
        logic [1:0] ab;
        m = 8'd0;
        e = 0;
        for (int v = 0; v < 4; v++) begin
            ab = 2'(v);
            g  = lab(ab);
            r  = (g & ~s0) | s1;
            m  = m | (r ^ g);
            if (r != g) e++;
        end
    endtask

    task automatic sweep(input string tag, input int s,
                         input logic [7:0] em, input int ee,
                         input bit repulse);
        bit ok;
        ok = 1'b1;
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c <= s; c++) begin
                if (k > 0 || c > 0) begin
                    @(negedge clk);
                    set_start(1'b0);
                end
                if (key_v !== 4'(k) || busy_v !== 1'b1 || done_v !== 1'b0)
                    ok = 1'b0;
                if (repulse && k == 1 && c == 0) set_start(1'b1);
            end
        end
        chk({tag, "_keyseq"}, 32'(ok), 32'd1);
        @(negedge clk);
        set_start(1'b0);
        chk({tag, "_done"}, 32'(done_v), 32'd1);
        chk({tag, "_busy_fin"}, 32'(busy_v), 32'd0);
        chk({tag, "_key_fin"}, 32'(key_v), 32'd0);
        chk({tag, "_mask"}, 32'(mask_v), 32'(em));
        chk({tag, "_err"}, 32'(err_v), 32'(ee));
        chk({tag, "_pass"}, 32'(pass_v), 32'(em == 8'd0));
        @(negedge clk);
        chk({tag, "_done_low"}, 32'(done_v), 32'd0);
        chk({tag, "_mask_hold"}, 32'(mask_v), 32'(em));
    endtask

    typedef struct {
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] mask;
        int         err;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [7:0] rm, r0, r1;
        int         re;
        int         n;
        bit         seen;

        tbl[0] = '{8'h00, 8'h00, 8'h00, 0};
        tbl[1] = '{8'h20, 8'h00, 8'h20, 3};
        tbl[2] = '{8'h40, 8'h04, 8'h44, 3};
        tbl[3] = '{8'h00, 8'h01, 8'h01, 2};
        tbl[4] = '{8'h00, 8'hFF, 8'hFF, 4};

        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        s0_a = 0; s1_a = 0; s0_b = 0; s1_b = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sel = 1'(i);
            chk("rst_key", 32'(key_v), 32'd0);
            chk("rst_busy", 32'(busy_v), 32'd0);
            chk("rst_done", 32'(done_v), 32'd0);
            chk("rst_pass", 32'(pass_v), 32'd0);
            chk("rst_mask", 32'(mask_v), 32'd0);
            chk("rst_err", 32'(err_v), 32'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 2; i++) begin
            sel = 1'(i);
            for (int t = 0; t < 5; t++) begin
                set_fault(tbl[t].s0, tbl[t].s1);
                sweep($sformatf("tbl%0d_s%0d", t, i), i ? 0 : 2,
                      tbl[t].mask, tbl[t].err, 1'b0);
            end
        end

        for (int t = 0; t < 12; t++) begin
            sel = 1'($urandom_range(0, 1));
            r0 = 8'($urandom) & 8'($urandom) & 8'($urandom);
            r1 = 8'($urandom) & 8'($urandom) & 8'($urandom);
            set_fault(r0, r1);
            ref_sweep(r0, r1, rm, re);
            sweep($sformatf("rnd%0d", t), sel ? 0 : 2, rm, re, 1'b0);
        end

        sel = 1'b0;
        set_fault(8'h00, 8'h00);
        sweep("repulse", 2, 8'h00, 0, 1'b1);

        // Reset at E0+5 discards a partial sweep.
        set_fault(8'h20, 8'h00);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_key", 32'(key_a), 32'd0);
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_mask", 32'(mask_a), 32'd0);
        chk("abort_err", 32'(err_a), 32'd0);
        chk("abort_pass", 32'(pass_a), 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done_a) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        // Back-to-back sweeps on the S=0 instance with start held.
        sel = 1'b1;
        set_fault(8'h20, 8'h00);
        @(negedge clk);
        start_b = 1'b1;
        seen = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (key_b !== 2'(k) || busy_b !== 1'b1) seen = 1'b0;
        end
        chk("b2b_keyseq", 32'(seen), 32'd1);
        @(negedge clk);
        chk("b2b_done1", 32'(done_b), 32'd1);
        chk("b2b_mask1", 32'(mask_b), 32'h20);
        chk("b2b_err1", 32'(err_b), 32'd3);
        set_fault(8'h00, 8'h00);
        @(negedge clk);
        chk("b2b_idle_busy", 32'(busy_b), 32'd0);
        chk("b2b_idle_done", 32'(done_b), 32'd0);
        @(negedge clk);
        chk("b2b_rebusy", 32'(busy_b), 32'd1);
        chk("b2b_clr_mask", 32'(mask_b), 32'd0);
        chk("b2b_clr_err", 32'(err_b), 32'd0);
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done2_wait", 32'(n), 32'd4);
        chk("b2b_pass2", 32'(pass_b), 32'd1);
        chk("b2b_mask2", 32'(mask_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_lab_checker.md
# gate_lab_checker

Self-checking stimulus driver for the two-input gate lab board logic. It sits on the opposite side of the key/LED interface: it drives the `key` bus, sweeps all four (a, b) combinations, and samples the returned `led` bus after a settle delay. Each sample is compared against the expected XOR, AND, NAND and NOR patterns, including both forms of each De Morgan pair. It accumulates a per-LED fail mask and a vector error count, then reports pass/fail with a one-cycle done pulse.

## Interface
- `w_key`, default 4, width of key bus driven to the lab logic; must be ≥ 2
- `w_led`, default 8, width of led bus read back; must be ≥ 8; bits above 7 are ignored
- `settle_cycles`, default 2, extra cycles key is held before led is sampled; 0 is legal

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `start` in 1: begin a sweep; honoured only in IDLE
- `key` out `w_key`: stimulus; bit0 = a, bit1 = b, upper bits always 0
- `led` in `w_led`: response from the lab logic under test
- `busy` out 1: sweep in progress
- `done` out 1: single-cycle pulse at sweep end
- `pass` out 1: 1 when last sweep had `fail_mask` == 0
- `fail_mask` out 8: bit i set if `led[i]` mismatched on any vector
- `err_count` out 3: number of vectors (0..4) with at least one mismatch

## Operation
- States:
  - IDLE: `key` = 0, `busy` = 0. On `start`, go to DRIVE: vector index v = 0, clear `fail_mask`, `err_count`, `pass`.
  - DRIVE: `key[1:0]` = v (b = v[1], a = v[0]). Hold for `settle_cycles`+1 cycles. On the last cycle, sample `led[7:0]`.
  - After sampling:
    - If v < 3: increment v, stay in DRIVE, reload the settle counter.
    - If v = 3: go to DONE.
  - DONE: one cycle, `done` = 1, `busy` = 0, `key` = 0. Then go to IDLE.
- Expected values per vector:
  - led0 = led1 = led3 = a^b
  - led2 = a&b
  - led4 = led5 = ~(a&b)
  - led6 = led7 = ~(a|b)
- Per sample:
  - mismatch = `led[7:0]` ^ expected
  - `fail_mask` |= mismatch
  - `err_count` += 1 if mismatch ≠ 0; saturates at 4 (cannot exceed by construction)
- `pass` = (`fail_mask` == 0), registered in the DONE cycle.
- `fail_mask`, `err_count`, `pass` hold their values in IDLE until the next accepted `start`.
- `start` while `busy` or in DONE is ignored; no queueing.
- The settle counter width is sized to hold `settle_cycles`. There is no wrap beyond the configured value.

## Timing
- Reset (`rst_n` = 0 at a rising edge):
  - state = IDLE
  - `key` = 0, `busy` = 0, `done` = 0, `pass` = 0
  - `fail_mask` = 0, `err_count` = 0
- Reset mid-sweep aborts immediately. No `done` pulse is issued and partial results are discarded.
- Let E0 be the edge that samples `start`. With S = `settle_cycles`:
  - From E0: `key` = 0 (v0), `busy` = 1.
  - At E0 + (S+1)·k for k = 1..4: vector k−1 is sampled. At the same edge, `key` advances to vector k (k < 4).
  - After E0 + 4(S+1): `done` = 1 and `busy` = 0 for one cycle; `key` = 0.
  - With S = 2, `done` is high in the cycle after edge E0+12.
- `led` is sampled only at the edges listed above. Glitches between samples are ignored.
- A `start` held high across DONE is accepted again once in IDLE. Earliest re-acceptance is the edge after the `done` cycle.

## Test plan
- Correct lab model, S = 2: `start` pulse → `key` sequence 0,1,2,3, each held 3 cycles. `done` appears 12 edges after start. `pass` = 1, `fail_mask` = 0x00, `err_count` = 0.
- `led[5]` stuck at 0: sweep → `fail_mask` = 0x20, `err_count` = 3, `pass` = 0. Mismatches occur on vectors 0, 1 and 2.
- `led[2]` stuck at 1 and `led[6]` stuck at 0:
  - `led[2]` mismatches on vectors 0, 1, 2; `led[6]` on vector 0.
  - Result: `fail_mask` = 0x44, `err_count` = 3.
- `start` re-pulsed mid-sweep → ignored; `done` timing unchanged. Assert `rst_n` = 0 at edge E0+5 → next cycle `key` = 0, `busy` = 0, `done` never pulses, results = 0.
- S = 0: `key` changes every cycle and `done` follows 4 edges after start. Back-to-back sweeps with `start` held high: the second sweep begins the edge after `done`, and results are cleared on acceptance.
